// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, operand
// forwarding selects and the in-flight scoreboard entry.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned FCNT_W = 2;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } sb_entry_t;

  // A producer one stage ahead in ID sits in MEM during the consumer's EX;
  // the youngest producer wins.
  function automatic fwd_sel_t fwd_pick(input logic [2:0] m);
    fwd_sel_t sel;
    if (m[2])      sel = FWD_EXMEM;
    else if (m[1]) sel = FWD_MEMWB;
    else           sel = FWD_RF;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one decode-stage source register against the EX/MEM/WB
// scoreboard entries; returns {match_ex, match_mem, match_wb}.
module hazard_match
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             src_rd,
  input  logic [2:0]       ent_valid,
  input  logic [REG_W-1:0] ex_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic [REG_W-1:0] wb_dest,
  output logic [2:0]       match
);

  logic live;

  // r0 is never a real dependency, so a zero source or zero dest never matches
  always_comb begin
    live     = src_rd && (src != '0);
    match[2] = live && ent_valid[2] && (ex_dest  == src);
    match[1] = live && ent_valid[1] && (mem_dest == src);
    match[0] = live && ent_valid[0] && (wb_dest  == src);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding control for a 5-stage pipeline. Define
// HAZARD_FORWARD_EN to enable operand forwarding (only load-use stalls).
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  sb_entry_t         ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        ent_valid;
  logic [2:0]        match_a, match_b;
  logic              hazard;

  assign ent_valid = {ex_q.valid, mem_q.valid, wb_q.valid};

  hazard_match u_match_a (
    .src       (id_rs),
    .src_rd    (id_valid),
    .ent_valid (ent_valid),
    .ex_dest   (ex_q.dest),
    .mem_dest  (mem_q.dest),
    .wb_dest   (wb_q.dest),
    .match     (match_a)
  );

  hazard_match u_match_b (
    .src       (id_rt),
    .src_rd    (id_valid & id_uses_rt),
    .ent_valid (ent_valid),
    .ex_dest   (ex_q.dest),
    .mem_dest  (mem_q.dest),
    .wb_dest   (wb_q.dest),
    .match     (match_b)
  );

`ifdef HAZARD_FORWARD_EN
  logic     unused_sb;
  fwd_sel_t fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  assign unused_sb = ^{mem_q.is_load, wb_q.is_load};
  assign hazard    = ex_q.is_load & (match_a[2] | match_b[2]);

  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!(stall || bubble)) begin
      fwd_a_d = fwd_pick(match_a);
      fwd_b_d = fwd_pick(match_b);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  logic unused_sb;

  assign unused_sb = ^{ex_q.is_load, mem_q.is_load, wb_q.is_load};
  assign hazard    = (|match_a) | (|match_b);
  assign fwd_a     = FWD_RF;
  assign fwd_b     = FWD_RF;
`endif

  // The redirect cycle itself bubbles the wrong-path ID instruction; the
  // FLUSH state then holds flush for FLUSH_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      FLUSH: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (ex_redirect)         fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
        else if (fcnt_q == '0)   state_d = RUN;
        else                     fcnt_d  = fcnt_q - FCNT_W'(1);
      end
      default: begin
        if (ex_redirect) begin
          state_d = FLUSH;
          fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
          bubble  = 1'b1;
        end else if (hazard) begin
          state_d = STALL;
          stall   = 1'b1;
          bubble  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    endcase
    if (!rst_n) begin
      stall  = 1'b0;
      bubble = 1'b0;
      flush  = 1'b0;
    end
  end

  always_comb begin
    ex_d.valid   = id_valid & id_reg_write & ~bubble & ~flush;
    ex_d.dest    = id_dest;
    ex_d.is_load = id_mem_read;
    mem_d        = ex_q;
    wb_d         = mem_q;
    cnt_d        = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed pipeline scenarios
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;
  localparam int CW = 4;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_dest;
  logic          id_uses_rt, id_reg_write, id_mem_read, ex_redirect;
  logic          stall, bubble, flush;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .ex_redirect  (ex_redirect),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Issue history: slot (cycle mod 8) records what entered EX after that
  // cycle; a producer issued k cycles ago is k stages ahead (1=EX..3=WB).
  bit h_wr   [8];
  int h_dest [8];
  bit h_load [8];
  int mcyc = 0;
  int flush_left = 0;
  int exp_fa = 0, exp_fb = 0, exp_cnt = 0;
  bit model_ok = 1'b0;

  function automatic int youngest(input int src, input bit rd);
    if (!rd || src == 0) return 0;
    for (int k = 1; k <= 3; k++)
      if (h_wr[(mcyc - k) & 7] && h_dest[(mcyc - k) & 7] == src) return k;
    return 0;
  endfunction

  function automatic int age_to_fwd(input int age);
    if (age == 1) return 1;
    if (age == 2) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin : model
    int age_a, age_b;
    bit hz, e_stall, e_flush, e_bubble;
    age_a = youngest(int'(id_rs), id_valid);
    age_b = youngest(int'(id_rt), id_valid && id_uses_rt);
    if (FWD_EN)
      hz = (age_a == 1 || age_b == 1) && h_load[(mcyc - 1) & 7];
    else
      hz = (age_a != 0) || (age_b != 0);
    e_flush  = rst_n && (flush_left > 0);
    e_stall  = rst_n && hz && !ex_redirect && (flush_left == 0);
    e_bubble = rst_n && (e_stall || e_flush || ex_redirect);

    if (model_ok) begin
      chk("m_stall",  int'(stall),       int'(e_stall));
      chk("m_bubble", int'(bubble),      int'(e_bubble));
      chk("m_flush",  int'(flush),       int'(e_flush));
      chk("m_fwd_a",  int'(fwd_a),       exp_fa);
      chk("m_fwd_b",  int'(fwd_b),       exp_fb);
      chk("m_count",  int'(stall_count), exp_cnt);
    end

    if (!rst_n) begin
      for (int i = 0; i < 8; i++) h_wr[i] = 1'b0;
      mcyc = 0; flush_left = 0; exp_fa = 0; exp_fb = 0; exp_cnt = 0;
      model_ok = 1'b1;
    end else begin
      h_wr[mcyc & 7]   = id_valid && id_reg_write && !e_bubble && !e_flush;
      h_dest[mcyc & 7] = int'(id_dest);
      h_load[mcyc & 7] = id_mem_read;
      mcyc++;
      if (ex_redirect)         flush_left = FC;
      else if (flush_left > 0) flush_left--;
      if (!FWD_EN || e_bubble) begin
        exp_fa = 0; exp_fb = 0;
      end else begin
        exp_fa = age_to_fwd(age_a);
        exp_fb = age_to_fwd(age_b);
      end
      if (e_stall && exp_cnt < (1 << CW) - 1) exp_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit rn; bit v; int rs; int rt; bit urt; int dest; bit rw; bit mr; bit redir;
  } stim_t;

  function automatic stim_t nop();
    stim_t x;
    x.rn = 1'b1; x.v = 1'b0; x.rs = 0; x.rt = 0; x.urt = 1'b0;
    x.dest = 0; x.rw = 1'b0; x.mr = 1'b0; x.redir = 1'b0;
    return x;
  endfunction

  function automatic stim_t alu(input int d, input int s, input int t);
    stim_t x;
    x = nop();
    x.v = 1'b1; x.rs = s; x.rt = t; x.urt = 1'b1; x.dest = d; x.rw = 1'b1;
    return x;
  endfunction

  function automatic stim_t lw(input int d, input int base);
    stim_t x;
    x = nop();
    x.v = 1'b1; x.rs = base; x.rt = d; x.dest = d; x.rw = 1'b1; x.mr = 1'b1;
    return x;
  endfunction

  task automatic step(input stim_t s);
    @(posedge clk); #1;
    rst_n        = s.rn;
    id_valid     = s.v;
    id_rs        = 5'(s.rs);
    id_rt        = 5'(s.rt);
    id_uses_rt   = s.urt;
    id_dest      = 5'(s.dest);
    id_reg_write = s.rw;
    id_mem_read  = s.mr;
    ex_redirect  = s.redir;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    stim_t s;
    s = nop(); s.rn = 1'b0;
    step(s); step(s);
  endtask

  // Holds an instruction in ID while it is stalled, with a bounded wait.
  task automatic issue(input stim_t s);
    int n;
    n = 0;
    step(s);
    while (stall === 1'b1 && n < 8) begin
      n++;
      step(s);
    end
    if (n >= 8) chk("stall_timeout", int'(stall), 0);
  endtask

  initial begin : drive
    stim_t s, w;
    rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; ex_redirect = 1'b0;

    // Reset state
    do_reset();
    step(nop());
    chk("rst_stall",  int'(stall), 0);
    chk("rst_bubble", int'(bubble), 0);
    chk("rst_flush",  int'(flush), 0);
    chk("rst_fwd_a",  int'(fwd_a), 0);
    chk("rst_fwd_b",  int'(fwd_b), 0);
    chk("rst_count",  int'(stall_count), 0);

`ifdef HAZARD_FORWARD_EN
    // lw r5 ; add r6,r5,r7 -> one stall, then MEM/WB forward on A
    do_reset();
    step(lw(5, 1));
    step(alu(6, 5, 7));
    chk("lu_stall",  int'(stall), 1);
    chk("lu_bubble", int'(bubble), 1);
    step(alu(6, 5, 7));
    chk("lu_stall_clear", int'(stall), 0);
    step(nop());
    chk("lu_fwd_a", int'(fwd_a), 2);
    chk("lu_fwd_b", int'(fwd_b), 0);
    chk("lu_count", int'(stall_count), 1);

    // add r3 ; sub r4,r3,r3 -> EX/MEM forward on both operands
    do_reset();
    step(alu(3, 1, 2));
    step(alu(4, 3, 3));
    chk("fw_stall", int'(stall), 0);
    step(nop());
    chk("fw_fwd_a", int'(fwd_a), 1);
    chk("fw_fwd_b", int'(fwd_b), 1);
`else
    // add r3 ; use r3 -> three stall cycles, then RUN without forwarding
    do_reset();
    step(alu(3, 1, 2));
    for (int i = 0; i < 3; i++) begin
      step(alu(5, 3, 4));
      chk("nf_stall", int'(stall), 1);
    end
    step(alu(5, 3, 4));
    chk("nf_stall_clear", int'(stall), 0);
    step(nop());
    chk("nf_fwd_a", int'(fwd_a), 0);
    chk("nf_fwd_b", int'(fwd_b), 0);
    chk("nf_count", int'(stall_count), 3);
`endif

    // Redirect coinciding with a load-use hazard
    do_reset();
    step(lw(5, 1));
    s = alu(6, 5, 7); s.redir = 1'b1;
    step(s);
    chk("rd_stall",  int'(stall), 0);
    chk("rd_bubble", int'(bubble), 1);
    step(nop());
    chk("rd_flush1", int'(flush), 1);
    chk("rd_stall1", int'(stall), 0);
    step(nop());
    chk("rd_flush2", int'(flush), 1);
    chk("rd_stall2", int'(stall), 0);
    step(alu(8, 6, 6));
    chk("rd_flush_end", int'(flush), 0);
    chk("rd_no_entry",  int'(stall), 0);
    chk("rd_count",     int'(stall_count), 0);

    // Write r0 then read r0
    do_reset();
    step(alu(0, 1, 2));
    step(alu(4, 0, 0));
    chk("r0_stall", int'(stall), 0);
    step(nop());
    chk("r0_fwd_a", int'(fwd_a), 0);
    chk("r0_fwd_b", int'(fwd_b), 0);

    // Reset in the middle of a stall abandons the scoreboard
    do_reset();
    w = FWD_EN ? lw(3, 1) : alu(3, 1, 2);
    step(w);
`ifndef HAZARD_FORWARD_EN
    step(alu(5, 3, 4));
    chk("mr_stall_pre", int'(stall), 1);
`endif
    s = alu(5, 3, 4); s.rn = 1'b0;
    step(s);
    chk("mr_stall_in_rst",  int'(stall), 0);
    chk("mr_bubble_in_rst", int'(bubble), 0);
    step(alu(5, 3, 4));
    chk("mr_stall",  int'(stall), 0);
    chk("mr_bubble", int'(bubble), 0);
    chk("mr_flush",  int'(flush), 0);
    chk("mr_fwd_a",  int'(fwd_a), 0);
    chk("mr_count",  int'(stall_count), 0);

    // Counter saturation: 20+ stall cycles into a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      issue(lw(1, 2));
      issue(alu(3, 1, 4));
    end
    step(nop());
    chk("sat_count", int'(stall_count), 15);

    // Randomized traffic over a small register set
    do_reset();
    for (int i = 0; i < 800; i++) begin
      s.rn    = ($urandom_range(0, 59) != 0);
      s.v     = ($urandom_range(0, 9) < 8);
      s.rs    = int'($urandom_range(0, 4));
      s.rt    = int'($urandom_range(0, 4));
      s.urt   = ($urandom_range(0, 1) == 1);
      s.dest  = int'($urandom_range(0, 4));
      s.rw    = ($urandom_range(0, 3) != 0);
      s.mr    = ($urandom_range(0, 2) == 0);
      s.redir = ($urandom_range(0, 24) == 0);
      step(s);
    end
    step(nop());
    step(nop());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
